// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared fetch-stage types and constants
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // 65-bit instruction-buffer entry
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - instruction buffer FIFO, DEPTH entries, clear empties it in one cycle
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  // pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr && !rst) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: one outstanding imem read feeding a decode buffer
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        addr_valid_i,
  output logic        addr_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  state, state_nx;
  logic [31:0]   addr_q;
  logic          discard_q, discard_nx;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;
  logic          push, pop, accept, aligned;

  always_comb begin
    addr_ready_o  = !rst && (state == ST_IDLE) && !flush_i && (count < FULL);
    accept        = addr_valid_i && addr_ready_o;
    aligned       = (addr_i[1:0] == 2'b00);
    instr_valid_o = !rst && (count != '0);
    pop           = instr_valid_o && instr_ready_i && !flush_i;
    state_nx      = state;
    discard_nx    = discard_q;
    push          = 1'b0;
    push_data     = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (aligned) begin
            state_nx = ST_REQ;
          end else begin
            push            = 1'b1;
            push_data.pc    = addr_i;
            push_data.fault = 1'b1;
          end
        end
      end
      // a flushed request still has to complete its grant; only its response is dropped
      ST_REQ: begin
        if (flush_i)    discard_nx = 1'b1;
        if (imem_gnt_i) state_nx   = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_nx   = ST_IDLE;
          discard_nx = 1'b0;
          if (!discard_q && !flush_i) begin
            push            = 1'b1;
            push_data.instr = imem_rdata_i;
            push_data.pc    = addr_q;
          end
        end else if (flush_i) begin
          discard_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      discard_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= state_nx;
      discard_q <= discard_nx;
      if (accept && aligned) addr_q <= addr_i;
    end
  end

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_i),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  assign imem_req_o    = !rst && (state == ST_REQ);
  assign imem_addr_o   = imem_req_o ? addr_q : '0;
  assign instr_o       = instr_valid_o ? head.instr : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;
  assign instr_fault_o = instr_valid_o && head.fault;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch with randomized fetch/flush/reset traffic
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic        addr_valid_i;
  logic        addr_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_fault_o;
  logic        instr_valid_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (addr_i),
    .addr_valid_i  (addr_valid_i),
    .addr_ready_o  (addr_ready_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_fault_o (instr_fault_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          max_gw = 0;
  int          max_rw = 0;
  bit          fixed_w = 1'b1;
  bit          stray = 1'b0;
  bit          override = 1'b0;
  logic [31:0] override_data = 32'h0;
  logic [31:0] last_aligned = 32'h0;
  int          stall = 0;

  // instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h2008_0005;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // memory responder: grant after 0..max_gw cycles, respond 0..max_rw cycles after grant
  initial begin : mem_model
    int          gwait;
    int          rwait;
    bit          pend;
    logic [31:0] paddr;
    gwait = 0; rwait = 0; pend = 1'b0; paddr = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (stray) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        stray         = 1'b0;
      end else if (pend) begin
        if (rwait == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = override ? override_data : mem_word(paddr);
          override      = 1'b0;
          pend          = 1'b0;
        end else begin
          rwait--;
        end
      end else if (imem_req_o) begin
        if (gwait == 0) begin
          imem_gnt_i = 1'b1;
          pend       = 1'b1;
          paddr      = imem_addr_o;
          rwait      = fixed_w ? max_rw : int'($urandom_range(max_rw, 0));
        end else begin
          gwait--;
        end
      end else begin
        gwait = fixed_w ? max_gw : int'($urandom_range(max_gw, 0));
      end
    end
  end

  // issue side: every accepted address becomes one expected buffer entry
  always @(negedge clk) begin
    if (!rst && addr_valid_i && addr_ready_o) begin
      if (addr_i[1:0] == 2'b00) begin
        expq.push_back('{mem_word(addr_i), addr_i, 1'b0});
        last_aligned = addr_i;
      end else begin
        expq.push_back('{32'h0, addr_i, 1'b1});
      end
    end
  end

  // monitor: compares each decode handshake against the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_outputs", imem_addr_o | instr_o | instr_pc_o |
            {28'h0, imem_req_o, addr_ready_o, instr_valid_o, instr_fault_o}, 32'h0);
      expq.delete();
      stall = 0;
    end else begin
      if (imem_req_o) check("req_addr", imem_addr_o, last_aligned);
      if (instr_valid_o && instr_ready_i && !flush_i) begin
        stall = 0;
        if (expq.size() == 0) begin
          check("unexpected_instr_pc", instr_pc_o, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("instr", instr_o, e.instr);
          check("instr_pc", instr_pc_o, e.pc);
          check_bit("instr_fault", instr_fault_o, e.fault);
        end
      end else if (expq.size() != 0) begin
        stall++;
        if (stall > 200) begin
          check("delivery_timeout_pending", 32'(expq.size()), 32'h0);
          stall = 0;
        end
      end
      if (flush_i) expq.delete();
    end
  end

  task automatic issue(input logic [31:0] a);
    int n;
    n = 0;
    addr_i       = a;
    addr_valid_i = 1'b1;
    while (!addr_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_bit("issue_timeout_ready", addr_ready_o, 1'b1);
    tick();
    addr_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr_i = 32'h0; addr_valid_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // minimum latency with a zero-wait memory
    instr_ready_i = 1'b1;
    issue(RESET_PC);
    check_bit("lat_t1_valid", instr_valid_o, 1'b0);
    tick();
    check_bit("lat_t2_valid", instr_valid_o, 1'b0);
    tick();
    check_bit("lat_t3_valid", instr_valid_o, 1'b1);
    check("lat_t3_pc", instr_pc_o, RESET_PC);
    repeat (2) tick();

    // full buffer blocks new addresses until decode pops
    instr_ready_i = 1'b0;
    issue(32'h0000_3000);
    issue(32'h0000_3004);
    repeat (4) tick();
    addr_i = 32'h0000_3008;
    addr_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_bit("full_ready", addr_ready_o, 1'b0);
      tick();
    end
    instr_ready_i = 1'b1;
    tick();
    issue(32'h0000_3008);
    repeat (6) tick();

    // request held stable while grant is withheld
    max_gw = 4;
    repeat (2) tick();
    issue(32'h0000_3004);
    for (int i = 0; i < 4; i++) begin
      check_bit("hold_req", imem_req_o, 1'b1);
      check("hold_addr", imem_addr_o, 32'h0000_3004);
      tick();
    end
    max_gw = 0;
    repeat (4) tick();

    // flush while waiting for the response drops that word
    max_rw = 3;
    repeat (2) tick();
    issue(32'h0000_3200);
    tick();
    override      = 1'b1;
    override_data = 32'hDEAD_BEEF;
    flush_i       = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (5) tick();
    max_rw = 0;
    issue(32'h0000_3100);
    repeat (5) tick();

    // misaligned address produces a fault entry without a memory request
    issue(32'h0000_3002);
    check_bit("mis_no_req", imem_req_o, 1'b0);
    check_bit("mis_valid", instr_valid_o, 1'b1);
    check_bit("mis_fault", instr_fault_o, 1'b1);
    check("mis_pc", instr_pc_o, 32'h0000_3002);
    tick();
    check_bit("mis_no_req2", imem_req_o, 1'b0);
    repeat (2) tick();

    // reset during REQ abandons the fetch; a stray response is ignored
    max_gw = 3;
    repeat (2) tick();
    issue(RESET_PC);
    check_bit("rstreq_req", imem_req_o, 1'b1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("stray_no_valid", instr_valid_o, 1'b0);
      check_bit("stray_no_req", imem_req_o, 1'b0);
    end
    max_gw = 0;

    // randomized traffic
    fixed_w = 1'b0;
    max_gw  = 2;
    max_rw  = 2;
    for (int c = 0; c < 1500; c++) begin
      addr_valid_i  = 1'($urandom_range(1, 0));
      addr_i        = 32'h0000_3000 + ($urandom_range(255, 0) << 2);
      if ($urandom_range(7, 0) == 0) addr_i[1:0] = 2'($urandom_range(3, 1));
      instr_ready_i = ($urandom_range(9, 0) < 7);
      flush_i       = ($urandom_range(49, 0) == 0);
      rst           = ($urandom_range(199, 0) == 0);
      tick();
    end
    addr_valid_i = 1'b0; flush_i = 1'b0; rst = 1'b0; instr_ready_i = 1'b1;
    repeat (30) tick();
    check("drain_pending", 32'(expq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the instruction-buffer entry count (legal values 2..8).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 addr_i  in  32  SHALL carry the fetch address from the PC register.
REQ-005 addr_valid_i  in  1  SHALL mark addr_i as presented.
REQ-006 addr_ready_o  out  1  SHALL mark addr_i as accepted this cycle (address consumed, PC may advance).
REQ-007 flush_i  in  1  SHALL discard all buffered and in-flight fetches (branch/jump redirect).
REQ-008 imem_req_o / imem_addr_o  out  1/32  SHALL form the instruction-memory request.
REQ-009 imem_gnt_i  in  1  SHALL acknowledge the request.
REQ-010 imem_rvalid_i / imem_rdata_i  in  1/32  SHALL return the read word.
REQ-011 instr_o / instr_pc_o  out  32/32  SHALL carry the head instruction word and its address.
REQ-012 instr_fault_o  out  1  SHALL flag a misaligned-fetch entry.
REQ-013 instr_valid_o / instr_ready_i  out/in  1/1  SHALL form the decode-side handshake.

Function
REQ-014 FSM SHALL have states IDLE, REQ, WAIT; at most one memory transaction outstanding.
REQ-015 addr_ready_o SHALL be 1 only when state==IDLE, flush_i==0 and buffer count < DEPTH.
REQ-016 Aligned accept (addr_i[1:0]==0) SHALL latch addr_i and move IDLE->REQ.
REQ-017 In REQ, imem_req_o SHALL be 1 with imem_addr_o stable until imem_gnt_i; grant moves REQ->WAIT.
REQ-018 In WAIT, imem_rvalid_i SHALL push {rdata, latched addr, fault=0} into the buffer and move WAIT->IDLE.
REQ-019 Latency: accept at cycle t, gnt at t+1, rvalid at t+2 -> instr_valid_o at t+3 (minimum 3 cycles).
REQ-020 Misaligned accept SHALL issue no memory request and SHALL push {32'h0, addr_i, fault=1} in the same cycle; state stays IDLE.
REQ-021 Buffer SHALL be FIFO; pop occurs when instr_valid_o && instr_ready_i; instr_valid_o = (count != 0).
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order, including at count==DEPTH-1.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH+1).
REQ-024 flush_i SHALL empty the buffer the same cycle (pop and push suppressed) and block new accepts that cycle.
REQ-025 flush_i in REQ SHALL keep imem_req_o asserted until grant and set a discard flag; flush_i in WAIT SHALL set the discard flag.
REQ-026 A response with the discard flag set SHALL be dropped (no push), clearing the flag and moving to IDLE.
REQ-027 imem_rvalid_i outside WAIT SHALL be ignored; imem_gnt_i outside REQ SHALL be ignored.

Reset
REQ-028 rst SHALL force state IDLE, buffer empty, pointers 0, discard flag 0.
REQ-029 During and after rst: imem_req_o=0, imem_addr_o=0, addr_ready_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_fault_o=0.
REQ-030 rst mid-transaction SHALL abandon the transaction; a late imem_rvalid_i SHALL be ignored per REQ-027.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the reset PC constant 32'h0000_3000 used by PC and fetch benches.
REQ-032 The buffer SHALL be one sub-module, if_fifo (parameterised DEPTH, 65-bit entries: instr, pc, fault).

Verification
REQ-033 Reset, then addr_i=32'h0000_3000, zero-wait memory returning 32'h2008_0005 -> instr_valid_o at t+3 with instr_pc_o=32'h0000_3000.
REQ-034 instr_ready_i=0, fetch 3000, 3004 -> addr_ready_o=0 for 3008 until a pop; order 3000, 3004 preserved.
REQ-035 imem_gnt_i held 0 for 4 cycles -> imem_req_o and imem_addr_o=32'h0000_3004 stable throughout.
REQ-036 flush_i in WAIT, then rvalid with 32'hDEAD_BEEF -> word dropped; next fetch 32'h0000_3100 delivered alone.
REQ-037 addr_i=32'h0000_3002 -> no imem_req_o; entry with instr_fault_o=1, instr_pc_o=32'h0000_3002.
REQ-038 rst asserted in REQ -> all outputs zero next cycle; stray rvalid afterwards produces no instr_valid_o.
